// File: rtl/pipelined_prefix_adder.sv
// Pipelined Sklansky prefix adder with valid/ready handshakes on both sides.
// Optional subtract support is compiled in with `define PREFIX_ADDER_SUB_EN.
module pipelined_prefix_adder #(
    parameter int LEVELS       = 3,
    parameter int WIDTH        = 2**LEVELS,
    parameter int STAGE_LEVELS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
`ifdef PREFIX_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy
);

    // Handshake: a transfer happens on an edge where valid & ready are both high.
    // The whole pipe moves together whenever the output slot is empty or drained.
    localparam int NGROUPS = (LEVELS + STAGE_LEVELS - 1) / STAGE_LEVELS;

    // Slot 0 holds carry-in; slot k+1 holds bit k. Level LEVELS only touches
    // slot WIDTH, folding the top bit into the carry-out group.
    function automatic logic [WIDTH:0] prefix_g(input logic [WIDTH:0] g_in,
                                                input logic [WIDTH:0] p_in,
                                                input int lo, input int hi);
        logic [WIDTH:0] g, p, g_nx, p_nx;
        int k;
        g = g_in;
        p = p_in;
        for (int lv = 0; lv <= LEVELS; lv++) begin
            if (lv >= lo && lv < hi) begin
                g_nx = g;
                p_nx = p;
                for (int j = 0; j <= WIDTH; j++) begin
                    if (((j >> lv) & 1) == 1) begin
                        k       = ((j >> lv) << lv) - 1;
                        g_nx[j] = g[j] | (p[j] & g[k]);
                        p_nx[j] = p[j] & p[k];
                    end
                end
                g = g_nx;
                p = p_nx;
            end
        end
        return g;
    endfunction

    function automatic logic [WIDTH:0] prefix_p(input logic [WIDTH:0] p_in,
                                                input int lo, input int hi);
        logic [WIDTH:0] p, p_nx;
        int k;
        p = p_in;
        for (int lv = 0; lv <= LEVELS; lv++) begin
            if (lv >= lo && lv < hi) begin
                p_nx = p;
                for (int j = 0; j <= WIDTH; j++) begin
                    if (((j >> lv) & 1) == 1) begin
                        k       = ((j >> lv) << lv) - 1;
                        p_nx[j] = p[j] & p[k];
                    end
                end
                p = p_nx;
            end
        end
        return p;
    endfunction

    function automatic int grp_hi(input int s);
        return ((s + 1) * STAGE_LEVELS < LEVELS) ? (s + 1) * STAGE_LEVELS : LEVELS;
    endfunction

    logic [WIDTH-1:0] w_b;
    logic             w_cin;
    logic             w_advance;
    logic             w_busy;
    logic [WIDTH:0]   w_g_last;

    logic [WIDTH:0]   r_g    [NGROUPS];
    logic [WIDTH:0]   r_p    [NGROUPS];
    logic [WIDTH-1:0] r_praw [NGROUPS];
    logic             r_v    [NGROUPS];
    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

`ifdef PREFIX_ADDER_SUB_EN
    assign w_b   = sub ? ~b : b;
    assign w_cin = sub | carry_in;
`else
    assign w_b   = b;
    assign w_cin = carry_in;
`endif

    assign w_advance = !r_out_valid || out_ready;
    assign w_g_last  = prefix_g(r_g[NGROUPS-1], r_p[NGROUPS-1],
                                (NGROUPS - 1) * STAGE_LEVELS, LEVELS + 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NGROUPS; s++) begin
                r_v[s]    <= 1'b0;
                r_g[s]    <= '0;
                r_p[s]    <= '0;
                r_praw[s] <= '0;
            end
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
        end else if (w_advance) begin
            r_v[0]    <= in_valid;
            r_g[0]    <= {a & w_b, w_cin};
            r_p[0]    <= {a ^ w_b, w_cin};
            r_praw[0] <= a ^ w_b;
            for (int s = 1; s < NGROUPS; s++) begin
                r_v[s]    <= r_v[s-1];
                r_g[s]    <= prefix_g(r_g[s-1], r_p[s-1], (s - 1) * STAGE_LEVELS, grp_hi(s - 1));
                r_p[s]    <= prefix_p(r_p[s-1], (s - 1) * STAGE_LEVELS, grp_hi(s - 1));
                r_praw[s] <= r_praw[s-1];
            end
            r_out_valid <= r_v[NGROUPS-1];
            r_sum       <= r_praw[NGROUPS-1] ^ w_g_last[WIDTH-1:0];
            r_cout      <= w_g_last[WIDTH];
        end
    end

    always_comb begin
        w_busy = r_out_valid;
        for (int s = 0; s < NGROUPS; s++) begin
            w_busy = w_busy | r_v[s];
        end
    end

    assign in_ready  = w_advance;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign carry_out = r_cout;
    assign busy      = w_busy;

endmodule
